// File: rtl/bp_cce_inst_fetch_if.sv
// Config and fetch/decode signal bundle of the CCE microcode fetch stage.
// slave is the fetch stage itself; master drives config, start, stall and branch.
interface bp_cce_inst_fetch_if #(
    parameter int inst_width_p          = 48,
    parameter int inst_ram_addr_width_p = 8
);
    logic                             cfg_w_v_i;
    logic                             cfg_r_v_i;
    logic [inst_ram_addr_width_p-1:0] cfg_addr_i;
    logic [inst_width_p-1:0]          cfg_data_i;
    logic [inst_width_p-1:0]          cfg_data_o;
    logic                             cfg_data_v_o;
    logic                             start_i;
    logic                             stall_i;
    logic                             branch_v_i;
    logic [inst_ram_addr_width_p-1:0] branch_target_i;
    logic [inst_width_p-1:0]          inst_o;
    logic                             inst_v_o;
    logic [inst_ram_addr_width_p-1:0] pc_o;
    logic                             running_o;
    logic                             inst_err_o;

    modport master (
        output cfg_w_v_i, cfg_r_v_i, cfg_addr_i, cfg_data_i, start_i,
               stall_i, branch_v_i, branch_target_i,
        input  cfg_data_o, cfg_data_v_o, inst_o, inst_v_o, pc_o, running_o, inst_err_o
    );

    modport slave (
        input  cfg_w_v_i, cfg_r_v_i, cfg_addr_i, cfg_data_i, start_i,
               stall_i, branch_v_i, branch_target_i,
        output cfg_data_o, cfg_data_v_o, inst_o, inst_v_o, pc_o, running_o, inst_err_o
    );
endinterface

// File: rtl/bp_cce_inst_fetch.sv
// Purpose: CCE microcode fetch - instruction RAM + PC, one instruction per cycle to the decoder.
// Latency: 1 cycle from issued address to inst_o/pc_o; config reads return the cycle after the strobe.
// Backpressure: stall_i replays the current PC (wins over branch); BP_CCE_INST_PARITY_EN adds RAM parity.
module bp_cce_inst_fetch #(
    parameter int inst_width_p          = 48,
    parameter int num_inst_ram_els_p    = 256,
    parameter int inst_ram_addr_width_p = $clog2(num_inst_ram_els_p)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    bp_cce_inst_fetch_if.slave bus
);

`ifdef BP_CCE_INST_PARITY_EN
    localparam int ram_width_lp = inst_width_p + 1;
`else
    localparam int ram_width_lp = inst_width_p;
`endif

    typedef logic [inst_ram_addr_width_p-1:0] addr_t;
    typedef enum logic [1:0] {RESET, INIT, BOOT, RUN} state_e;

    state_e                  state_r, state_n;
    addr_t                   ex_pc_r;
    addr_t                   ram_addr;
    logic                    cfg_wr_en, cfg_rd_en, fetch_en;
    logic                    cfg_data_v_r;
    logic [ram_width_lp-1:0] mem [num_inst_ram_els_p];
    logic [ram_width_lp-1:0] rd_data_r;
    logic [ram_width_lp-1:0] wr_word;
    logic                    running;
    logic                    inst_bad;

    always_ff @(posedge clk_i) begin
        if (reset_i) state_r <= RESET;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n   = state_r;
        ram_addr  = bus.cfg_addr_i;
        cfg_wr_en = 1'b0;
        cfg_rd_en = 1'b0;
        fetch_en  = 1'b0;
        case (state_r)
            RESET: state_n = INIT;
            INIT: begin
                cfg_wr_en = bus.cfg_w_v_i;
                cfg_rd_en = bus.cfg_r_v_i & ~bus.cfg_w_v_i;
                if (bus.start_i) state_n = BOOT;
            end
            BOOT: begin
                fetch_en = 1'b1;
                ram_addr = '0;
                state_n  = RUN;
            end
            RUN: begin
                fetch_en = 1'b1;
                if (bus.stall_i)         ram_addr = ex_pc_r;
                else if (bus.branch_v_i) ram_addr = bus.branch_target_i;
                else                     ram_addr = ex_pc_r + addr_t'(1);
            end
            default: state_n = RESET;
        endcase
    end

`ifdef BP_CCE_INST_PARITY_EN
    // Even parity: stored bit makes the whole word XOR to zero.
    assign wr_word = {^bus.cfg_data_i, bus.cfg_data_i};
`else
    assign wr_word = bus.cfg_data_i;
`endif

    // RAM contents survive reset so a reboot can rerun the loaded microcode.
    always_ff @(posedge clk_i) begin
        if (cfg_wr_en && !reset_i) mem[ram_addr] <= wr_word;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_r    <= '0;
            ex_pc_r      <= '0;
            cfg_data_v_r <= 1'b0;
        end else begin
            cfg_data_v_r <= cfg_rd_en;
            if (cfg_rd_en || fetch_en) rd_data_r <= mem[ram_addr];
            if (fetch_en)              ex_pc_r   <= ram_addr;
        end
    end

    assign running = (state_r == RUN);

`ifdef BP_CCE_INST_PARITY_EN
    logic err_r;
    assign inst_bad = running & (^rd_data_r);

    always_ff @(posedge clk_i) begin
        if (reset_i)       err_r <= 1'b0;
        else if (inst_bad) err_r <= 1'b1;
    end

    assign bus.inst_err_o = err_r | inst_bad;
`else
    assign inst_bad       = 1'b0;
    assign bus.inst_err_o = 1'b0;
`endif

    assign bus.cfg_data_o   = rd_data_r[inst_width_p-1:0];
    assign bus.cfg_data_v_o = cfg_data_v_r;
    assign bus.inst_o       = rd_data_r[inst_width_p-1:0];
    assign bus.pc_o         = ex_pc_r;
    assign bus.running_o    = running;
    assign bus.inst_v_o     = running & ~bus.inst_err_o;

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Directed bench for bp_cce_inst_fetch: config load/readback, boot, stall/branch table, wrap, reboot, parity.
module tb_bp_cce_inst_fetch;
    localparam int W  = 48;
    localparam int N  = 256;
    localparam int AW = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bp_cce_inst_fetch_if #(.inst_width_p(W), .inst_ram_addr_width_p(AW)) bus ();

    bp_cce_inst_fetch #(.inst_width_p(W), .num_inst_ram_els_p(N)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          stall;
        logic          br;
        logic [AW-1:0] tgt;
        int            exp_pc;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [W-1:0] word_of(int i);
        return {16'hCAFE, 8'(i), 8'(255 - i), 16'(i * 37 + 5)};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_w_v_i       = 1'b0;
        bus.cfg_r_v_i       = 1'b0;
        bus.cfg_addr_i      = '0;
        bus.cfg_data_i      = '0;
        bus.start_i         = 1'b0;
        bus.stall_i         = 1'b0;
        bus.branch_v_i      = 1'b0;
        bus.branch_target_i = '0;
    endtask

    task automatic check_run(string tag, int exp_pc);
        check({tag, ".inst_v"},  64'(bus.inst_v_o),   64'd1);
        check({tag, ".pc"},      64'(bus.pc_o),       64'(exp_pc));
        check({tag, ".inst"},    64'(bus.inst_o),     64'(word_of(exp_pc)));
        check({tag, ".running"}, 64'(bus.running_o),  64'd1);
        check({tag, ".err"},     64'(bus.inst_err_o), 64'd0);
    endtask

    task automatic check_idle(string tag);
        check({tag, ".inst_v"},  64'(bus.inst_v_o),     64'd0);
        check({tag, ".running"}, 64'(bus.running_o),    64'd0);
        check({tag, ".pc"},      64'(bus.pc_o),         64'd0);
        check({tag, ".cfg_v"},   64'(bus.cfg_data_v_o), 64'd0);
        check({tag, ".err"},     64'(bus.inst_err_o),   64'd0);
    endtask

    task automatic boot(string tag);
        bus.start_i         = 1'b1;
        tick();
        bus.start_i         = 1'b0;
        check({tag, ".boot_v"},       64'(bus.inst_v_o),  64'd0);
        check({tag, ".boot_running"}, 64'(bus.running_o), 64'd0);
        // stall/branch must be ignored while booting
        bus.stall_i         = 1'b1;
        bus.branch_v_i      = 1'b1;
        bus.branch_target_i = 8'd9;
        tick();
        idle_inputs();
        check_run({tag, ".first"}, 0);
    endtask

    initial begin
        int pc;
        vecs[0]  = '{1'b0, 1'b0, 8'd0,   1};
        vecs[1]  = '{1'b1, 1'b0, 8'd0,   1};
        vecs[2]  = '{1'b1, 1'b0, 8'd0,   1};
        vecs[3]  = '{1'b1, 1'b0, 8'd0,   1};
        vecs[4]  = '{1'b0, 1'b0, 8'd0,   2};
        vecs[5]  = '{1'b0, 1'b1, 8'd1,   1};
        vecs[6]  = '{1'b1, 1'b1, 8'd3,   1};
        vecs[7]  = '{1'b0, 1'b1, 8'd3,   3};
        vecs[8]  = '{1'b0, 1'b1, 8'd3,   3};
        vecs[9]  = '{1'b0, 1'b0, 8'd0,   4};
        vecs[10] = '{1'b0, 1'b1, 8'd255, 255};
        vecs[11] = '{1'b0, 1'b0, 8'd0,   0};
        vecs[12] = '{1'b0, 1'b0, 8'd0,   1};

        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        check_idle("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < N; i++) begin
            bus.cfg_w_v_i  = 1'b1;
            bus.cfg_addr_i = 8'(i);
            bus.cfg_data_i = word_of(i);
            tick();
        end
        check("load.cfg_v", 64'(bus.cfg_data_v_o), 64'd0);

        bus.cfg_r_v_i  = 1'b1;
        bus.cfg_addr_i = 8'd5;
        bus.cfg_data_i = word_of(5);
        tick();
        check("wr_wins.cfg_v", 64'(bus.cfg_data_v_o), 64'd0);

        bus.cfg_w_v_i  = 1'b0;
        bus.cfg_addr_i = 8'd2;
        tick();
        bus.cfg_r_v_i  = 1'b0;
        check("rd2.cfg_v",    64'(bus.cfg_data_v_o), 64'd1);
        check("rd2.cfg_data", 64'(bus.cfg_data_o),   64'(word_of(2)));
        tick();
        check("rd2.cfg_v_drop", 64'(bus.cfg_data_v_o), 64'd0);

        bus.cfg_r_v_i  = 1'b1;
        bus.cfg_addr_i = 8'd5;
        tick();
        bus.cfg_r_v_i  = 1'b0;
        check("rd5.cfg_data", 64'(bus.cfg_data_o), 64'(word_of(5)));

        boot("boot1");

        for (int i = 0; i < 13; i++) begin
            bus.stall_i         = vecs[i].stall;
            bus.branch_v_i      = vecs[i].br;
            bus.branch_target_i = vecs[i].tgt;
            tick();
            check_run($sformatf("vec%0d", i), vecs[i].exp_pc);
        end
        idle_inputs();

        bus.cfg_w_v_i  = 1'b1;
        bus.cfg_addr_i = 8'd0;
        bus.cfg_data_i = '1;
        tick();
        check("run_wr.cfg_v", 64'(bus.cfg_data_v_o), 64'd0);
        check_run("run_wr", 2);
        bus.cfg_w_v_i  = 1'b0;
        bus.cfg_r_v_i  = 1'b1;
        tick();
        bus.cfg_r_v_i  = 1'b0;
        check("run_rd.cfg_v", 64'(bus.cfg_data_v_o), 64'd0);
        check_run("run_rd", 3);

        pc = 3;
        for (int k = 0; k < 260; k++) begin
            tick();
            pc = (pc + 1) % N;
            check_run($sformatf("line%0d", k), pc);
        end

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("midrun_reset");
        tick();
        check_idle("after_reset");
        boot("boot2");

`ifdef BP_CCE_INST_PARITY_EN
        tick();
        check_run("par.pc1", 1);
        dut.mem[2][W] = ~dut.mem[2][W];
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("par%0d.inst_v", k),  64'(bus.inst_v_o),   64'd0);
            check($sformatf("par%0d.err", k),     64'(bus.inst_err_o), 64'd1);
            check($sformatf("par%0d.running", k), 64'(bus.running_o),  64'd1);
            check($sformatf("par%0d.pc", k),      64'(bus.pc_o),       64'(2 + k));
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_idle("par_reset");
`else
        for (int k = 0; k < 4; k++) begin
            tick();
            check_run($sformatf("nopar%0d", k), k + 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
